mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath.

---
 rtl/mul_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a start/busy/done handshake.
module mul_div_unit #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int CW = (Width > 1) ? $clog2(Width) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [Width:0]     acc;        // product upper half / partial remainder
  logic [Width-1:0]   q;          // multiplier / dividend-quotient shift register
  logic [Width-1:0]   m;          // multiplicand / divisor magnitude
  logic [Width-1:0]   a_raw;
  logic               is_div, neg_res, neg_rem, zero_div;

  logic               sgn_op, a_neg, b_neg;
  logic [Width-1:0]   a_abs, b_abs;
  logic [Width:0]     mul_sum, div_sh, div_diff;
  logic [2*Width-1:0] prod, prod_fix;
  logic [Width-1:0]   quo_fix, rem_fix;

  always_comb begin
    sgn_op   = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_neg    = sgn_op & a_i[Width-1];
    b_neg    = sgn_op & b_i[Width-1];
    a_abs    = a_neg ? -a_i : a_i;
    b_abs    = b_neg ? -b_i : b_i;
    mul_sum  = acc + {1'b0, (q[0] ? m : '0)};
    div_sh   = {acc[Width-1:0], q[Width-1]};
    div_diff = div_sh - {1'b0, m};
    prod     = {acc[Width-1:0], q};
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -q : q;
    rem_fix  = neg_rem ? -acc[Width-1:0] : acc[Width-1:0];
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (op_i == OP_MULT || op_i == OP_MULTU)    state_nx = MUL;
          else if (op_i == OP_DIV || op_i == OP_DIVU) state_nx = DIV;
        end
      end
      MUL, DIV: if (cnt == CW'(Width - 1)) state_nx = FIX;
      FIX:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      done_o   <= 1'b0;
      div0_o   <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                acc     <= '0;
                q       <= b_abs;
                m       <= a_abs;
                neg_res <= a_neg ^ b_neg;
                is_div  <= 1'b0;
                cnt     <= '0;
              end
              OP_DIV, OP_DIVU: begin
                acc      <= '0;
                q        <= a_abs;
                m        <= b_abs;
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                zero_div <= (b_i == '0);
                a_raw    <= a_i;
                is_div   <= 1'b1;
                cnt      <= '0;
              end
              OP_MTHI: begin
                hi_o   <= a_i;
                div0_o <= 1'b0;
              end
              OP_MTLO: begin
                lo_o   <= a_i;
                div0_o <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {1'b0, mul_sum[Width:1]};
          q   <= {mul_sum[0], q[Width-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          // borrow out of the trial subtraction selects restore vs. keep
          if (!div_diff[Width]) begin
            acc <= div_diff;
            q   <= {q[Width-2:0], 1'b1};
          end else begin
            acc <= div_sh;
            q   <= {q[Width-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done_o <= 1'b1;
          if (is_div) begin
            if (zero_div) begin
              lo_o   <= '1;
              hi_o   <= a_raw;
              div0_o <= 1'b1;
            end else begin
              lo_o   <= quo_fix;
              hi_o   <= rem_fix;
              div0_o <= 1'b0;
            end
          end else begin
            {hi_o, lo_o} <= prod_fix;
            div0_o       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: a driver pushes model results, a monitor checks them on done.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div0;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mul_div_unit #(.Width(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .div0_o(div0), .hi_o(hi), .lo_o(lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         d0;
    string        tag;
  } exp_t;

  exp_t         sbq[$];
  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [W-1:0] hi_m, lo_m;
  logic         d0_m;
  logic         done_at_start;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rd);
    logic signed [63:0] sx, sy, sp;
    logic [63:0]        ux, uy, up;
    sx = $signed(x);
    sy = $signed(y);
    ux = 64'(x);
    uy = 64'(y);
    rh = hi_m; rl = lo_m; rd = d0_m;
    case (o)
      3'd0: begin sp = sx * sy; rh = sp[2*W-1:W]; rl = sp[W-1:0]; rd = 1'b0; end
      3'd1: begin up = ux * uy; rh = up[2*W-1:W]; rl = up[W-1:0]; rd = 1'b0; end
      3'd2: begin
        if (y == '0) begin rl = '1; rh = x; rd = 1'b1; end
        else begin
          sp = sx / sy; rl = sp[W-1:0];
          sp = sx % sy; rh = sp[W-1:0];
          rd = 1'b0;
        end
      end
      3'd3: begin
        if (y == '0) begin rl = '1; rh = x; rd = 1'b1; end
        else begin
          up = ux / uy; rl = up[W-1:0];
          up = ux % uy; rh = up[W-1:0];
          rd = 1'b0;
        end
      end
      3'd4: begin rh = x; rd = 1'b0; end
      3'd5: begin rl = x; rd = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input string tag, input bit track);
    exp_t        e;
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) check({tag, "_idle_timeout"}, 64'd1, 64'd0);
    done_at_start = done;
    op = o; a = x; b = y; start = 1'b1;
    model(o, x, y, e.hi, e.lo, e.d0);
    e.tag = tag;
    @(posedge clk);
    #1 start = 1'b0;
    if (track) begin
      hi_m = e.hi; lo_m = e.lo; d0_m = e.d0;
      if (o <= 3'd3) sbq.push_back(e);
      else begin
        @(negedge clk);
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
        check({tag, "_div0"}, div0, d0_m);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
      end
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sbq.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else begin
          e = sbq.pop_front();
          check({e.tag, "_hi"}, hi, e.hi);
          check({e.tag, "_lo"}, lo, e.lo);
          check({e.tag, "_div0"}, div0, e.d0);
          check({e.tag, "_busy_at_done"}, busy, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   busy_cnt, done_at, t;
    logic [W-1:0]  old_hi, old_lo, rx, ry;
    logic [2:0]    ro;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_m = '0; lo_m = '0; d0_m = 1'b0; done_at_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div0", div0, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);

    // Latency and busy width on the widest unsigned product
    issue(3'd1, '1, '1, "multu_max", 1'b1);
    busy_cnt = 0; done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_at = i;
    end
    check("multu_busy_cycles", 64'(busy_cnt), 64'd33);
    check("multu_done_latency", 64'(done_at), 64'd34);

    issue(3'd0, 32'hFFFF_FFFD, 32'h0000_0005, "mult_neg3x5", 1'b1);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minxmin", 1'b1);
    check("b2b_start_in_done_cycle", done_at_start, 1);
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7by2", 1'b1);
    issue(3'd3, 32'h0000_0007, 32'h0000_0002, "divu_7by2", 1'b1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1", 1'b1);
    issue(3'd3, 32'h0000_0007, 32'h0000_0000, "divu_by0", 1'b1);
    issue(3'd1, 32'h0000_0002, 32'h0000_0003, "multu_2x3", 1'b1);
    issue(3'd2, 32'h8000_0001, 32'h0000_0000, "div_by0_signed", 1'b1);

    // Start while busy is ignored; operands changing mid-operation have no effect
    old_hi = hi_m; old_lo = lo_m;
    issue(3'd3, 32'd100, 32'd7, "divu_100by7", 1'b1);
    repeat (5) @(negedge clk);
    op = 3'd1; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    check("hold_hi_while_busy", hi, old_hi);
    check("hold_lo_while_busy", lo, old_lo);

    issue(3'd4, 32'h1234_5678, '0, "mthi", 1'b1);
    issue(3'd5, 32'h9ABC_DEF0, '0, "mtlo", 1'b1);
    issue(3'd6, 32'hDEAD_BEEF, 32'h1, "noop6", 1'b1);

    // Reset around cycle 10 of a divide aborts it with no done
    issue(3'd2, 32'd1000, 32'd3, "div_abort", 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hi_m = '0; lo_m = '0; d0_m = 1'b0;
    @(negedge clk);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    check("abort_div0", div0, 0);
    repeat (40) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: ry = '1;
        2: rx = 32'h8000_0000;
        3: begin rx = 32'h8000_0000; ry = '1; end
        4: ry = 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue(ro, rx, ry, $sformatf("rand%0d_op%0d", n, ro), 1'b1);
    end

    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drain", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
